// File: rtl/clkdiv_bank.sv
// Bank of independent programmable clock dividers with a shared sync
// and a shared divisor write port; divisor changes land on period edges.
module clkdiv_bank #(
   parameter int NCH = 4,
   parameter int DIV_W = 16,
   parameter int RST_DIV = 256,
   localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [NCH-1:0]   en,
   input  logic             sync,
   input  logic             wr_en,
   input  logic [CH_W-1:0]  wr_ch,
   input  logic [DIV_W-1:0] wr_div,
   output logic [NCH-1:0]   clk_out,
   output logic [NCH-1:0]   tick,
   output logic [NCH-1:0]   pend
);

   localparam logic [DIV_W-1:0] RST_D = DIV_W'(RST_DIV);
   localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
   localparam logic [DIV_W-1:0] TWO   = DIV_W'(2);

   logic [DIV_W-1:0] act_q [NCH];
   logic [DIV_W-1:0] act_d [NCH];
   logic [DIV_W-1:0] nxt_q [NCH];
   logic [DIV_W-1:0] nxt_d [NCH];
   logic [DIV_W-1:0] cnt_q [NCH];
   logic [DIV_W-1:0] cnt_d [NCH];

   logic [NCH-1:0] pend_q, pend_d;
   logic [NCH-1:0] clk_q, clk_d;
   logic [NCH-1:0] tick_q, tick_d;

   logic [NCH-1:0] run;
   logic [NCH-1:0] last;
   logic [NCH-1:0] bnd;
   logic [NCH-1:0] hit;

   // Per-channel counter, waveform and divisor hand-over logic
   always_comb begin
      run    = '0;
      last   = '0;
      bnd    = '0;
      hit    = '0;
      pend_d = pend_q;
      clk_d  = '0;
      tick_d = '0;
      for (int i = 0; i < NCH; i++) begin
         act_d[i] = act_q[i];
         nxt_d[i] = nxt_q[i];
         cnt_d[i] = '0;

         run[i]  = en[i] && (act_q[i] >= TWO);
         last[i] = run[i] && (cnt_q[i] == act_q[i] - ONE);
         bnd[i]  = !run[i] || last[i] || sync;
         hit[i]  = wr_en && (wr_ch == CH_W'(i));

         // sync overrides the running count; stopped stays at zero
         if (run[i] && !sync) begin
            clk_d[i]  = cnt_q[i] < (act_q[i] >> 1);
            tick_d[i] = last[i];
            cnt_d[i]  = last[i] ? '0 : cnt_q[i] + ONE;
         end

         // a write on a boundary bypasses the pending slot
         if (hit[i]) begin
            if (bnd[i]) begin
               act_d[i]  = wr_div;
               pend_d[i] = 1'b0;
            end else begin
               nxt_d[i]  = wr_div;
               pend_d[i] = 1'b1;
            end
         end else if (bnd[i] && pend_q[i]) begin
            act_d[i]  = nxt_q[i];
            pend_d[i] = 1'b0;
         end
      end
   end

   // State registers; reset drops any pending divisor
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < NCH; i++) begin
            act_q[i] <= RST_D;
            nxt_q[i] <= RST_D;
            cnt_q[i] <= '0;
         end
         pend_q <= '0;
         clk_q  <= '0;
         tick_q <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            act_q[i] <= act_d[i];
            nxt_q[i] <= nxt_d[i];
            cnt_q[i] <= cnt_d[i];
         end
         pend_q <= pend_d;
         clk_q  <= clk_d;
         tick_q <= tick_d;
      end
   end

   assign clk_out = clk_q;
   assign tick    = tick_q;
   assign pend    = pend_q;

endmodule

// File: tb/tb_clkdiv_bank.sv
// Self-checking bench for clkdiv_bank: vector table for the
// divisor hand-over cases plus sequences for sync, stop and reset.
module tb_clkdiv_bank;

   localparam int NCH = 5;
   localparam int DIV_W = 16;
   localparam int RST_DIV = 4;
   localparam int CH_W = 3;

   logic             clk;
   logic             resetn;
   logic [NCH-1:0]   en;
   logic             sync;
   logic             wr_en;
   logic [CH_W-1:0]  wr_ch;
   logic [DIV_W-1:0] wr_div;
   logic [NCH-1:0]   clk_out;
   logic [NCH-1:0]   tick;
   logic [NCH-1:0]   pend;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [NCH-1:0]   en;
      logic             sync;
      logic             we;
      logic [CH_W-1:0]  ch;
      logic [DIV_W-1:0] div;
      logic [NCH-1:0]   c;
      logic [NCH-1:0]   t;
      logic [NCH-1:0]   p;
   } vec_t;

   typedef struct {
      logic [NCH-1:0] c;
      logic [NCH-1:0] t;
      logic [NCH-1:0] p;
   } exp_t;

   vec_t vecs[$];
   exp_t sbq[$];

   clkdiv_bank #(
      .NCH(NCH),
      .DIV_W(DIV_W),
      .RST_DIV(RST_DIV)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .en(en),
      .sync(sync),
      .wr_en(wr_en),
      .wr_ch(wr_ch),
      .wr_div(wr_div),
      .clk_out(clk_out),
      .tick(tick),
      .pend(pend)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string nm, logic [NCH-1:0] got, logic [NCH-1:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %b want %b", nm, got, want);
      end
   endtask

   task automatic add(logic [NCH-1:0] e, logic s, logic w,
                      logic [CH_W-1:0] ch, logic [DIV_W-1:0] d,
                      logic [NCH-1:0] c, logic [NCH-1:0] t,
                      logic [NCH-1:0] p);
      vec_t v;
      v.en = e; v.sync = s; v.we = w; v.ch = ch; v.div = d;
      v.c = c; v.t = t; v.p = p;
      vecs.push_back(v);
   endtask

   task automatic drv(logic [NCH-1:0] e, logic s, logic w,
                      logic [CH_W-1:0] ch, logic [DIV_W-1:0] d);
      en = e; sync = s; wr_en = w; wr_ch = ch; wr_div = d;
   endtask

   task automatic push(logic [NCH-1:0] c, logic [NCH-1:0] t,
                       logic [NCH-1:0] p);
      exp_t x;
      x.c = c; x.t = t; x.p = p;
      sbq.push_back(x);
   endtask

   task automatic edge_chk(string nm);
      exp_t x;
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         errors++;
         checks++;
         $display("FAIL %s: scoreboard empty", nm);
      end else begin
         x = sbq.pop_front();
         chk({nm, " clk_out"}, clk_out, x.c);
         chk({nm, " tick"}, tick, x.t);
         chk({nm, " pend"}, pend, x.p);
      end
   endtask

   task automatic step(string nm, logic [NCH-1:0] e, logic s, logic w,
                       logic [CH_W-1:0] ch, logic [DIV_W-1:0] d,
                       logic [NCH-1:0] c, logic [NCH-1:0] t,
                       logic [NCH-1:0] p);
      drv(e, s, w, ch, d);
      push(c, t, p);
      edge_chk(nm);
   endtask

   initial begin
      resetn = 1'b0;
      drv('0, 1'b0, 1'b0, '0, '0);

      // ch0 alone at D=4: 1,1,0,0 with tick on the last 0
      add(5'h01, 0, 0, 0, 0,  5'h01, 5'h00, 5'h00);
      add(5'h01, 0, 0, 0, 0,  5'h01, 5'h00, 5'h00);
      add(5'h01, 0, 0, 0, 0,  5'h00, 5'h00, 5'h00);
      add(5'h01, 0, 0, 0, 0,  5'h00, 5'h01, 5'h00);
      add(5'h01, 0, 0, 0, 0,  5'h01, 5'h00, 5'h00);
      add(5'h01, 0, 0, 0, 0,  5'h01, 5'h00, 5'h00);
      add(5'h01, 0, 0, 0, 0,  5'h00, 5'h00, 5'h00);
      add(5'h01, 0, 0, 0, 0,  5'h00, 5'h01, 5'h00);
      // write D=6 at cnt=1: pend two cycles, then 3 high/3 low
      add(5'h01, 0, 0, 0, 0,  5'h01, 5'h00, 5'h00);
      add(5'h01, 0, 1, 0, 6,  5'h01, 5'h00, 5'h01);
      add(5'h01, 0, 0, 0, 0,  5'h00, 5'h00, 5'h01);
      add(5'h01, 0, 0, 0, 0,  5'h00, 5'h01, 5'h00);
      add(5'h01, 0, 0, 0, 0,  5'h01, 5'h00, 5'h00);
      add(5'h01, 0, 0, 0, 0,  5'h01, 5'h00, 5'h00);
      add(5'h01, 0, 0, 0, 0,  5'h01, 5'h00, 5'h00);
      add(5'h01, 0, 0, 0, 0,  5'h00, 5'h00, 5'h00);
      add(5'h01, 0, 0, 0, 0,  5'h00, 5'h00, 5'h00);
      add(5'h01, 0, 0, 0, 0,  5'h00, 5'h01, 5'h00);
      // back to D=4 through the pending slot
      add(5'h01, 0, 1, 0, 4,  5'h01, 5'h00, 5'h01);
      add(5'h01, 0, 0, 0, 0,  5'h01, 5'h00, 5'h01);
      add(5'h01, 0, 0, 0, 0,  5'h01, 5'h00, 5'h01);
      add(5'h01, 0, 0, 0, 0,  5'h00, 5'h00, 5'h01);
      add(5'h01, 0, 0, 0, 0,  5'h00, 5'h00, 5'h01);
      add(5'h01, 0, 0, 0, 0,  5'h00, 5'h01, 5'h00);
      // D=4 period, D=5 written on the wrap edge: 2 high/3 low
      add(5'h01, 0, 0, 0, 0,  5'h01, 5'h00, 5'h00);
      add(5'h01, 0, 0, 0, 0,  5'h01, 5'h00, 5'h00);
      add(5'h01, 0, 0, 0, 0,  5'h00, 5'h00, 5'h00);
      add(5'h01, 0, 1, 0, 5,  5'h00, 5'h01, 5'h00);
      add(5'h01, 0, 0, 0, 0,  5'h01, 5'h00, 5'h00);
      add(5'h01, 0, 0, 0, 0,  5'h01, 5'h00, 5'h00);
      add(5'h01, 0, 0, 0, 0,  5'h00, 5'h00, 5'h00);
      add(5'h01, 0, 0, 0, 0,  5'h00, 5'h00, 5'h00);
      add(5'h01, 0, 0, 0, 0,  5'h00, 5'h01, 5'h00);

      #1;
      chk("reset clk_out", clk_out, '0);
      chk("reset tick", tick, '0);
      chk("reset pend", pend, '0);

      @(posedge clk);
      #1;
      en = 5'h01;
      resetn = 1'b1;

      for (int k = 0; k < vecs.size(); k++) begin
         drv(vecs[k].en, vecs[k].sync, vecs[k].we,
             vecs[k].ch, vecs[k].div);
         push(vecs[k].c, vecs[k].t, vecs[k].p);
         edge_chk($sformatf("row%0d", k));
      end

      // ch0 D=4, ch1 D=6 loaded while stopped, then sync
      drv('0, 1'b0, 1'b0, '0, '0);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      step("ldw0", 5'h00, 0, 1, 0, 4,  5'h00, 5'h00, 5'h00);
      step("ldw1", 5'h00, 0, 1, 1, 6,  5'h00, 5'h00, 5'h00);
      step("run0", 5'h03, 0, 0, 0, 0,  5'h03, 5'h00, 5'h00);
      step("run1", 5'h03, 0, 0, 0, 0,  5'h03, 5'h00, 5'h00);
      step("run2", 5'h03, 0, 0, 0, 0,  5'h02, 5'h00, 5'h00);
      step("sync", 5'h03, 1, 0, 0, 0,  5'h00, 5'h00, 5'h00);
      step("algn", 5'h03, 0, 0, 0, 0,  5'h03, 5'h00, 5'h00);

      // ch2: D=1 stops it, D=10 restarts; ch0/1 disabled mid-period
      step("d1w", 5'h04, 0, 1, 2, 1,  5'h04, 5'h00, 5'h04);
      step("d1a", 5'h04, 0, 0, 0, 0,  5'h04, 5'h00, 5'h04);
      step("d1b", 5'h04, 0, 0, 0, 0,  5'h00, 5'h00, 5'h04);
      step("d1c", 5'h04, 0, 0, 0, 0,  5'h00, 5'h04, 5'h00);
      for (int k = 0; k < 3; k++)
         step($sformatf("stop%0d", k), 5'h04, 0, 0, 0, 0,
              5'h00, 5'h00, 5'h00);
      step("d10w", 5'h04, 0, 1, 2, 10,  5'h00, 5'h00, 5'h00);
      for (int k = 0; k < 10; k++)
         step($sformatf("d10_%0d", k), 5'h04, 0, 0, 0, 0,
              (k < 5) ? 5'h04 : 5'h00,
              (k == 9) ? 5'h04 : 5'h00, 5'h00);

      // stray write, pending write, then async reset mid-period
      step("stray", 5'h04, 0, 1, 7, 3,  5'h04, 5'h00, 5'h00);
      step("pw8", 5'h04, 0, 1, 2, 8,  5'h04, 5'h00, 5'h04);
      drv(5'h04, 1'b0, 1'b0, '0, '0);
      #2;
      resetn = 1'b0;
      #1;
      chk("arst clk_out", clk_out, '0);
      chk("arst tick", tick, '0);
      chk("arst pend", pend, '0);
      @(posedge clk);
      #1;
      resetn = 1'b1;
      step("rel0", 5'h04, 0, 0, 0, 0,  5'h04, 5'h00, 5'h00);
      step("rel1", 5'h04, 0, 0, 0, 0,  5'h04, 5'h00, 5'h00);
      step("rel2", 5'h04, 0, 0, 0, 0,  5'h00, 5'h00, 5'h00);
      step("rel3", 5'h04, 0, 0, 0, 0,  5'h00, 5'h04, 5'h00);
      step("rel4", 5'h04, 0, 0, 0, 0,  5'h04, 5'h00, 5'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
